// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter/sequencer sharing one ALU among NUM_REQ requesters
// Define ALU_ARB_FIXED_PRIO_EN for fixed (lowest-index-wins) priority instead of round-robin.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_src_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_src_b,
  input  logic [NUM_REQ*3-1:0]  req_op_code,
  output logic [DATA_W-1:0]     alu_src_a,
  output logic [DATA_W-1:0]     alu_src_b,
  output logic [2:0]            alu_op_code,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_z_flag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DATA_W-1:0]     rsp_result,
  output logic                  rsp_z_flag
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   alu_src_a_q, alu_src_b_q, rsp_result_q;
  logic [2:0]          alu_op_code_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic                rsp_valid_q, rsp_z_flag_q;

  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic [2:0]          sel_op;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last (winning) write.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(k);
      end
    end
  end
`else
  localparam int CW = ID_W + 1;

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]   cand_w;

  // Scan from ptr upward, wrapping, and take the first valid requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_w      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_w = {1'b0, ptr_q} + CW'(k);
      if (cand_w >= CW'(NUM_REQ)) cand_w = cand_w - CW'(NUM_REQ);
      if (!grant_found && req_valid[cand_w[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_w[ID_W-1:0];
      end
    end
  end

  assign ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
`endif

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        sel_a  = req_src_a[i*DATA_W +: DATA_W];
        sel_b  = req_src_b[i*DATA_W +: DATA_W];
        sel_op = req_op_code[i*3 +: 3];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset_n && (state_q == IDLE) && grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      alu_src_a_q   <= '0;
      alu_src_b_q   <= '0;
      alu_op_code_q <= '0;
      rsp_id_q      <= '0;
      rsp_result_q  <= '0;
      rsp_z_flag_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q         <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            alu_src_a_q   <= sel_a;
            alu_src_b_q   <= sel_b;
            alu_op_code_q <= sel_op;
            rsp_id_q      <= grant_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q         <= ptr_d;
`endif
            state_q       <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_z_flag_q <= alu_z_flag;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_src_a   = alu_src_a_q;
  assign alu_src_b   = alu_src_b_q;
  assign alu_op_code = alu_op_code_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_z_flag  = rsp_z_flag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_src_a, req_src_b;
  logic [11:0]  req_op_code;
  logic [31:0]  alu_src_a, alu_src_b, alu_result;
  logic [2:0]   alu_op_code;
  logic         alu_z_flag;
  logic         rsp_valid, rsp_ready, rsp_z_flag;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;

  int vec_cnt = 0;
  int err_cnt = 0;

  alu_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src_a(req_src_a), .req_src_b(req_src_b), .req_op_code(req_op_code),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op_code(alu_op_code),
    .alu_result(alu_result), .alu_z_flag(alu_z_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_z_flag(rsp_z_flag)
  );

  always #5 clock = ~clock;

  // Bench ALU: 010 add, 110 sub, 011 xor, 000 and, 001 or.
  always_comb begin
    case (alu_op_code)
      3'b010:  alu_result = alu_src_a + alu_src_b;
      3'b110:  alu_result = alu_src_a - alu_src_b;
      3'b011:  alu_result = alu_src_a ^ alu_src_b;
      3'b000:  alu_result = alu_src_a & alu_src_b;
      3'b001:  alu_result = alu_src_a | alu_src_b;
      default: alu_result = 32'd0;
    endcase
    alu_z_flag = (alu_result == 32'd0);
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_src_a[i*32 +: 32] = a;
    req_src_b[i*32 +: 32] = b;
    req_op_code[i*3 +: 3] = op;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_src_a = '0;
    req_src_b = '0;
    req_op_code = '0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic wait_ready(input string name);
    bit ok = 0;
    for (int c = 0; c < 20; c++) begin
      if (|req_ready) begin ok = 1; break; end
      tick();
    end
    vec_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL %s: req_ready timeout, got %b want nonzero", name, req_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_src_a = {4{32'hdead_beef}};
    req_src_b = {4{32'h1234_5678}};
    req_op_code = {4{3'b010}};
    tick();
    tick();
    vec_cnt++;
    if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    vec_cnt++;
    if ({rsp_valid, rsp_z_flag, rsp_id} !== 4'b0) begin err_cnt++; $display("FAIL reset_rsp_ctl: got %b want 0000", {rsp_valid, rsp_z_flag, rsp_id}); end
    vec_cnt++;
    if ({alu_src_a, alu_src_b, alu_op_code, rsp_result} !== '0) begin err_cnt++; $display("FAIL reset_data: got %h/%h/%h/%h want 0", alu_src_a, alu_src_b, alu_op_code, rsp_result); end
  endtask

  task automatic test_single();
    apply_reset();
    set_req(0, 32'd5, 32'd7, 3'b010);
    req_valid = 4'b0001;
    #1;
    wait_ready("single");
    vec_cnt++;
    if (req_ready !== 4'b0001) begin err_cnt++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    vec_cnt++;
    if ({alu_src_a, alu_src_b, alu_op_code} !== {32'd5, 32'd7, 3'b010}) begin err_cnt++; $display("FAIL single_alu_ops: got %0d %0d %b want 5 7 010", alu_src_a, alu_src_b, alu_op_code); end
    vec_cnt++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0) begin err_cnt++; $display("FAIL single_exec: rsp_valid %b req_ready %b want 0 0000", rsp_valid, req_ready); end
    tick();
    vec_cnt++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_z_flag} !== {1'b1, 2'd0, 32'd12, 1'b0}) begin err_cnt++; $display("FAIL single_rsp: got v%b id%0d res%0d z%b want v1 id0 res12 z0", rsp_valid, rsp_id, rsp_result, rsp_z_flag); end
    rsp_ready = 1'b1;
    tick();
    vec_cnt++;
    if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL single_done: rsp_valid got %b want 0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [31:0] res [4] = '{32'd3, 32'd14, 32'd25, 32'd36};
    int grants = 0;
    int last = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'(i*10 + 1), 32'(i + 2), 3'b010);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 40 && grants < 5; cyc++) begin
      if (rsp_valid) begin
        vec_cnt++;
        if (rsp_id !== 2'(order[grants-1]) || rsp_result !== res[order[grants-1]]) begin
          err_cnt++;
          $display("FAIL rr_rsp: got id%0d res%0d want id%0d res%0d", rsp_id, rsp_result, order[grants-1], res[order[grants-1]]);
        end
      end
      if (|req_ready) begin
        vec_cnt++;
        if (req_ready !== 4'(1 << order[grants])) begin err_cnt++; $display("FAIL rr_grant%0d: got %b want %b", grants, req_ready, 4'(1 << order[grants])); end
        if (grants > 0) begin
          vec_cnt++;
          if (cyc - last !== 3) begin err_cnt++; $display("FAIL rr_spacing: got %0d cycles want 3", cyc - last); end
        end
        last = cyc;
        grants++;
      end
      if (grants < 5) tick();
    end
    vec_cnt++;
    if (grants !== 5) begin err_cnt++; $display("FAIL rr_count: got %0d grants want 5", grants); end
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
  endtask

  task automatic test_fixed_prio();
    int grants = 0;
    apply_reset();
    set_req(1, 32'd4, 32'd4, 3'b010);
    set_req(3, 32'd6, 32'd6, 3'b010);
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
      if (|req_ready) begin
        vec_cnt++;
        if (req_ready !== 4'b0010) begin err_cnt++; $display("FAIL fixed_grant%0d: got %b want 0010", grants, req_ready); end
        grants++;
      end
      if (grants < 4) tick();
    end
    vec_cnt++;
    if (grants !== 4) begin err_cnt++; $display("FAIL fixed_count: got %0d grants want 4", grants); end
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_req(2, 32'd100, 32'd23, 3'b110);
    set_req(0, 32'd1, 32'd1, 3'b010);
    set_req(1, 32'd2, 32'd2, 3'b010);
    req_valid = 4'b0100;
    #1;
    wait_ready("backpressure");
    vec_cnt++;
    if (req_ready !== 4'b0100) begin err_cnt++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0011;
    tick();
    for (int k = 0; k < 5; k++) begin
      vec_cnt++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_z_flag, req_ready} !== {1'b1, 2'd2, 32'd77, 1'b0, 4'b0000}) begin
        err_cnt++;
        $display("FAIL bp_hold%0d: got v%b id%0d res%0d z%b rdy%b want v1 id2 res77 z0 rdy0000", k, rsp_valid, rsp_id, rsp_result, rsp_z_flag, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    vec_cnt++;
    if (rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_prehs: rsp_valid got %b want 1", rsp_valid); end
    tick();
    vec_cnt++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin err_cnt++; $display("FAIL bp_release: v%b rdy%b want v0 rdy0001", rsp_valid, req_ready); end
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
  endtask

  task automatic test_zero_flag();
    apply_reset();
    set_req(3, 32'd9, 32'd9, 3'b110);
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    #1;
    wait_ready("zero");
    vec_cnt++;
    if (req_ready !== 4'b1000) begin err_cnt++; $display("FAIL zero_grant: got %b want 1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    vec_cnt++;
    if (alu_op_code !== 3'b110) begin err_cnt++; $display("FAIL zero_op_pass: got %b want 110", alu_op_code); end
    tick();
    vec_cnt++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_z_flag} !== {1'b1, 2'd3, 32'd0, 1'b1}) begin err_cnt++; $display("FAIL zero_rsp: got v%b id%0d res%0d z%b want v1 id3 res0 z1", rsp_valid, rsp_id, rsp_result, rsp_z_flag); end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_req(1, 32'd40, 32'd2, 3'b010);
    set_req(3, 32'd8, 32'd1, 3'b010);
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    wait_ready("reset_mid");
    tick();
    reset_n = 1'b0;
    #1;
    vec_cnt++;
    if ({rsp_valid, rsp_id, rsp_z_flag, req_ready} !== 8'b0) begin err_cnt++; $display("FAIL rstmid_ctl: v%b id%0d z%b rdy%b want all 0", rsp_valid, rsp_id, rsp_z_flag, req_ready); end
    vec_cnt++;
    if ({alu_src_a, alu_src_b, alu_op_code, rsp_result} !== '0) begin err_cnt++; $display("FAIL rstmid_data: got %h/%h/%h/%h want 0", alu_src_a, alu_src_b, alu_op_code, rsp_result); end
    tick();
    req_valid = 4'b0000;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vec_cnt++;
      if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_norsp%0d: rsp_valid got %b want 0", k, rsp_valid); end
    end
    req_valid = 4'b1010;
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0010) begin err_cnt++; $display("FAIL rstmid_first_grant: got %b want 0010", req_ready); end
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int grants = 0;
    apply_reset();
    set_req(2, 32'hF0, 32'h0F, 3'b001);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 30 && grants < 3; cyc++) begin
      if (rsp_valid) begin
        vec_cnt++;
        if (rsp_id !== 2'd2 || rsp_result !== 32'hFF) begin err_cnt++; $display("FAIL b2b_rsp: got id%0d res%h want id2 resff", rsp_id, rsp_result); end
      end
      if (|req_ready) begin
        vec_cnt++;
        if (req_ready !== 4'b0100) begin err_cnt++; $display("FAIL b2b_grant%0d: got %b want 0100", grants, req_ready); end
        grants++;
      end
      if (grants < 3) tick();
    end
    vec_cnt++;
    if (grants !== 3) begin err_cnt++; $display("FAIL b2b_count: got %0d want 3", grants); end
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef ALU_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
`endif
    test_backpressure();
    test_zero_flag();
    test_reset_mid();
    test_back_to_back();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
